// File: rtl/half_adder_cell.sv
// Single-bit half adder: sum and carry of two bits, purely combinational.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b;
    assign c_out = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with a combinational result, a
// registered copy of the last accepted operand pair, a one-cycle valid
// strobe and a saturating count of accepted pairs that produced a carry.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c_out,
    output logic [WIDTH-1:0] s_q,
    output logic [WIDTH-1:0] c_out_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [WIDTH-1:0] s_p0;
    logic [WIDTH-1:0] c_p0;
    logic             vld_p0;
    logic [CNT_W-1:0] cnt_p0;

    // Count up by one, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Lanes are separate cells so no carry can ripple between bit positions.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .s     (s[i]),
            .c_out (c_out[i])
        );
    end

    // ---- stage p0: capture accepted operands, hold otherwise ----

    // Result registers load the combinational lanes on an accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_p0 <= '0;
            c_p0 <= '0;
        end else if (in_valid) begin
            s_p0 <= s;
            c_p0 <= c_out;
        end
    end

    // Valid strobe is in_valid delayed by one cycle; reset drops any pending pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= in_valid;
        end
    end

    // Tally accepted pairs where at least one lane generated a carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
        end else if (in_valid && (|c_out)) begin
            cnt_p0 <= sat_inc(cnt_p0);
        end
    end

    assign s_q       = s_p0;
    assign c_out_q   = c_p0;
    assign out_valid = vld_p0;
    assign carry_cnt = cnt_p0;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench: a 1-lane DUT with a 2-bit counter and a 4-lane DUT
// with an 8-bit counter, both checked every cycle against an arithmetic model.
module tb_half_adder;

    logic clk;
    logic rst_n;

    logic       a1, b1, v1;
    logic       s1, c1, sq1, cq1, ov1;
    logic [1:0] cnt1;

    logic [3:0] a4, b4;
    logic       v4;
    logic [3:0] s4, c4, sq4, cq4;
    logic       ov4;
    logic [7:0] cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [3:0] m_sq1 = '0, m_cq1 = '0, m_sq4 = '0, m_cq4 = '0;
    logic       m_ov1 = 1'b0, m_ov4 = 1'b0;
    int         m_cnt1 = 0, m_cnt4 = 0;

    half_adder #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
        .s(s1), .c_out(c1), .s_q(sq1), .c_out_q(cq1),
        .out_valid(ov1), .carry_cnt(cnt1)
    );

    half_adder #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4),
        .s(s4), .c_out(c4), .s_q(sq4), .c_out_q(cq4),
        .out_valid(ov4), .carry_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lane-wise arithmetic add: returns {carry[3:0], sum[3:0]}.
    function automatic logic [7:0] ladd(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] sm, cy;
        int t;
        for (int i = 0; i < 4; i++) begin
            t = int'(x[i]) + int'(y[i]);
            sm[i] = (t % 2) != 0;
            cy[i] = (t / 2) != 0;
        end
        return {cy, sm};
    endfunction

    // Reference behaviour: capture on accept, clamp the carry tally.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sq1 <= '0; m_cq1 <= '0; m_ov1 <= 1'b0; m_cnt1 <= 0;
            m_sq4 <= '0; m_cq4 <= '0; m_ov4 <= 1'b0; m_cnt4 <= 0;
        end else begin
            m_ov1 <= v1;
            m_ov4 <= v4;
            if (v1) begin
                m_sq1 <= ladd({3'b0, a1}, {3'b0, b1}) & 8'h0f;
                m_cq1 <= ladd({3'b0, a1}, {3'b0, b1}) >> 4;
                if (ladd({3'b0, a1}, {3'b0, b1}) >> 4 != 0)
                    m_cnt1 <= (m_cnt1 + 1 > 3) ? 3 : m_cnt1 + 1;
            end
            if (v4) begin
                m_sq4 <= ladd(a4, b4) & 8'h0f;
                m_cq4 <= ladd(a4, b4) >> 4;
                if (ladd(a4, b4) >> 4 != 0)
                    m_cnt4 <= (m_cnt4 + 1 > 255) ? 255 : m_cnt4 + 1;
            end
        end
    end

    // Every falling edge: all outputs of both DUTs against the model.
    always @(negedge clk) begin
        logic [7:0] e1, e4;
        e1 = ladd({3'b0, a1}, {3'b0, b1});
        e4 = ladd(a4, b4);
        chk("s1",    32'(s1),   32'(e1[0]));
        chk("c1",    32'(c1),   32'(e1[4]));
        chk("s_q1",  32'(sq1),  32'(m_sq1[0]));
        chk("c_q1",  32'(cq1),  32'(m_cq1[0]));
        chk("ov1",   32'(ov1),  32'(m_ov1));
        chk("cnt1",  32'(cnt1), m_cnt1);
        chk("s4",    32'(s4),   32'(e4[3:0]));
        chk("c4",    32'(c4),   32'(e4[7:4]));
        chk("s_q4",  32'(sq4),  32'(m_sq4));
        chk("c_q4",  32'(cq4),  32'(m_cq4));
        chk("ov4",   32'(ov4),  32'(m_ov4));
        chk("cnt4",  32'(cnt4), m_cnt4);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int seq [5] = '{1, 2, 3, 3, 3};
    int tab_s [4] = '{0, 1, 1, 0};
    int tab_c [4] = '{0, 0, 0, 1};

    initial begin
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
        a4 = '0;   b4 = '0;   v4 = 1'b0;
        repeat (2) step();
        chk("rst_sq1", 32'(sq1), 0);
        chk("rst_ov1", 32'(ov1), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        chk("rst_cnt4", 32'(cnt4), 0);
        rst_n = 1'b1;

        // Truth table of a single lane, idle registered path
        for (int i = 0; i < 4; i++) begin
            a1 = i[0];
            b1 = i[1];
            #50;
            chk("tt_s", 32'(s1), tab_s[i]);
            chk("tt_c", 32'(c1), tab_c[i]);
        end

        // One accepted pair on each DUT, then hold
        step();
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        a4 = 4'b1010; b4 = 4'b0110; v4 = 1'b1;
        #1;
        chk("w4_s", 32'(s4), 32'(4'b1100));
        chk("w4_c", 32'(c4), 32'(4'b0010));
        step();
        chk("acc_sq1", 32'(sq1), 0);
        chk("acc_cq1", 32'(cq1), 1);
        chk("acc_ov1", 32'(ov1), 1);
        chk("acc_cnt1", 32'(cnt1), 1);
        chk("acc_sq4", 32'(sq4), 32'(4'b1100));
        chk("acc_cq4", 32'(cq4), 32'(4'b0010));
        chk("acc_cnt4", 32'(cnt4), 1);
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        v4 = 1'b0; a4 = 4'b1111; b4 = 4'b1111;
        step();
        chk("hold_sq1", 32'(sq1), 0);
        chk("hold_cq1", 32'(cq1), 1);
        chk("hold_ov1", 32'(ov1), 0);
        chk("hold_cnt1", 32'(cnt1), 1);
        chk("hold_sq4", 32'(sq4), 32'(4'b1100));
        chk("hold_cnt4", 32'(cnt4), 1);

        // Fresh counter, five carrying pairs: saturates at 3
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("sat_cnt1", 32'(cnt1), seq[k]);
        end
        v1 = 1'b0;

        // Reset asserted between edges while a pair is pending
        step();
        a4 = 4'b1111; b4 = 4'b1011; v4 = 1'b1; v1 = 1'b1;
        step();
        #4;
        rst_n = 1'b0;
        #1;
        chk("mr_sq1", 32'(sq1), 0);
        chk("mr_cq1", 32'(cq1), 0);
        chk("mr_ov1", 32'(ov1), 0);
        chk("mr_cnt1", 32'(cnt1), 0);
        chk("mr_sq4", 32'(sq4), 0);
        chk("mr_cq4", 32'(cq4), 0);
        chk("mr_ov4", 32'(ov4), 0);
        chk("mr_cnt4", 32'(cnt4), 0);
        chk("mr_s4", 32'(s4), 32'(4'b0100));
        chk("mr_c4", 32'(c4), 32'(4'b1011));
        a4 = 4'b0110;
        #1;
        chk("mr_s4b", 32'(s4), 32'(4'b1101));
        chk("mr_c4b", 32'(c4), 32'(4'b0010));
        step();
        chk("mr_hold_ov4", 32'(ov4), 0);
        chk("mr_hold_cnt4", 32'(cnt4), 0);
        v1 = 1'b0; v4 = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_ov1", 32'(ov1), 0);
        chk("post_ov4", 32'(ov4), 0);
        chk("post_cnt4", 32'(cnt4), 0);

        // Randomised traffic with occasional asynchronous resets
        repeat (400) begin
            step();
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            v1 = $urandom_range(0, 3) != 0;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            v4 = $urandom_range(0, 3) != 0;
            rst_n = $urandom_range(0, 49) != 0;
        end
        rst_n = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
